// File: rtl/fetch_pc_if.sv
// Fetch-stage bundle: decode control inputs, instruction-memory port and the
// {if_instr, if_pc, if_valid} presentation to decode.
interface fetch_pc_if;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_offset;
   logic        jump;
   logic [25:0] jump_target;
   logic        halt_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_valid;
   logic        fault;
   logic [1:0]  state;

   modport master (
      input  stall, branch_taken, branch_offset, jump, jump_target, halt_req, imem_data,
      output imem_addr, if_instr, if_pc, if_valid, fault, state
   );

   modport slave (
      output stall, branch_taken, branch_offset, jump, jump_target, halt_req, imem_data,
      input  imem_addr, if_instr, if_pc, if_valid, fault, state
   );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter and fetch sequencer feeding a 1-cycle synchronous instruction
// memory; re-pairs the returned word with its PC and handles stall, redirect, halt, fault.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          MEM_BYTES = 128
) (
   input  logic        clk,
   input  logic        rst,
   fetch_pc_if.master  bus
);

   typedef enum logic [1:0] {
      BOOT = 2'b00,
      RUN  = 2'b01,
      HALT = 2'b10
   } state_t;

   localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

   state_t      state_q, state_d;
   logic [31:0] pc_p0, pc_d;
   logic [31:0] if_pc_p1, if_pc_d;
   logic        vld_p1, vld_d;
   logic        fault_q, fault_d;

   logic        redirect;
   logic [31:0] link;
   logic [31:0] tgt;

   // A fetch address is unusable if misaligned or if any byte of the word lies past memory.
   function automatic logic bad_addr(input logic [31:0] a);
      return (a[1:0] != 2'b00) || ((a + 32'd3) >= MEM_LIMIT);
   endfunction

   function automatic logic [31:0] branch_tgt(input logic [31:0] lk, input logic [15:0] off);
      return lk + {{14{off[15]}}, off, 2'b00};
   endfunction

   function automatic logic [31:0] jump_tgt(input logic [31:0] lk, input logic [25:0] idx);
      return {lk[31:28], idx, 2'b00};
   endfunction

   always_comb begin
      link     = if_pc_p1 + 32'd4;
      redirect = vld_p1 && (bus.jump || bus.branch_taken);
      tgt      = bus.jump ? jump_tgt(link, bus.jump_target)
                          : branch_tgt(link, bus.branch_offset);
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_p0;
      if_pc_d = if_pc_p1;
      vld_d   = vld_p1;
      fault_d = fault_q;
      unique case (state_q)
         BOOT: begin
            state_d = RUN;
            if_pc_d = pc_p0;
            vld_d   = 1'b1;
            pc_d    = pc_p0 + 32'd4;
         end
         RUN: begin
            if (bus.halt_req) begin
               state_d = HALT;
               vld_d   = 1'b0;
            end else if (bad_addr(pc_p0)) begin
               state_d = HALT;
               fault_d = 1'b1;
               vld_d   = 1'b0;
            end else if (redirect) begin
               // The fall-through word sampled at this edge is squashed: one bubble.
               pc_d  = tgt;
               vld_d = 1'b0;
            end else if (!bus.stall) begin
               if_pc_d = pc_p0;
               vld_d   = 1'b1;
               pc_d    = pc_p0 + 32'd4;
            end
         end
         HALT: begin
            vld_d = 1'b0;
         end
         default: begin
            state_d = HALT;
            vld_d   = 1'b0;
         end
      endcase
   end

   // Stage p0 -> p1: address issued to memory, word returns paired with if_pc_p1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= BOOT;
         pc_p0    <= RESET_PC;
         if_pc_p1 <= RESET_PC;
         vld_p1   <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_p0    <= pc_d;
         if_pc_p1 <= if_pc_d;
         vld_p1   <= vld_d;
         fault_q  <= fault_d;
      end
   end

   // While stalled the memory re-reads the held PC so if_instr stays stable.
   assign bus.imem_addr = (state_q == RUN && bus.stall && !redirect) ? if_pc_p1 : pc_p0;
   assign bus.if_instr  = bus.imem_data;
   assign bus.if_pc     = if_pc_p1;
   assign bus.if_valid  = vld_p1;
   assign bus.fault     = fault_q;
   assign bus.state     = state_q;

endmodule
